// File: rtl/game_pkg.sv
// Shared game round types for the sequencer and the HUD/text renderer.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_PLAY  = 3'd2,
    S_DYING = 3'd3,
    S_OVER  = 3'd4,
    S_WIN   = 3'd5
  } game_state_t;

  localparam int MAX_LIVES = 3;

endpackage

// File: rtl/ghost_release_mask.sv
// Frame timer to per-ghost enable mask.
// Ghost i runs once timer reaches i*RELEASE_FRAMES.
module ghost_release_mask #(
  parameter int NUM_GHOSTS     = 4,
  parameter int RELEASE_FRAMES = 64,
  parameter int TIMER_W        = 8
) (
  input  logic [TIMER_W-1:0]    timer,
  input  logic                  play,
  output logic [NUM_GHOSTS-1:0] mask
);

  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_GHOSTS; i++) begin
      mask[i] = play &&
        (32'(timer) >= 32'(i * RELEASE_FRAMES));
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Round state machine, frame timer, lives and
// ghost release sequencing for the ghost units.
module game_sequencer
  import game_pkg::*;
#(
  parameter int NUM_GHOSTS     = 4,
  parameter int START_LIVES    = 3,
  parameter int READY_FRAMES   = 120,
  parameter int DEATH_FRAMES   = 90,
  parameter int RELEASE_FRAMES = 64,
  parameter int TIMER_W        = 8
) (
  input  logic                  frame_clk,
  input  logic                  Reset_n,
  input  logic                  start,
  input  logic [NUM_GHOSTS-1:0] die_vec,
  input  logic                  level_clear,
  output logic                  game_reset,
  output logic [NUM_GHOSTS-1:0] ghost_en,
  output logic [1:0]            lives,
  output logic [2:0]            state_o,
  output logic                  game_over,
  output logic                  win
);

  localparam logic [TIMER_W-1:0] RDY_LAST =
    TIMER_W'(READY_FRAMES - 1);
  localparam logic [TIMER_W-1:0] DTH_LAST =
    TIMER_W'(DEATH_FRAMES - 1);
  localparam logic [1:0] LIVES0 = 2'(START_LIVES);

  game_state_t           state;
  logic [TIMER_W-1:0]    timer;
  logic [TIMER_W-1:0]    timer_inc;
  logic [TIMER_W-1:0]    mask_timer;
  logic [NUM_GHOSTS-1:0] mask;
  logic                  start_q;
  logic                  start_edge;
  logic                  caught;
  logic                  enter_play;
  logic                  stay_play;

  assign start_edge = start & ~start_q;
  assign caught     = |die_vec;
  assign timer_inc  = (&timer) ? timer : timer + 1'b1;
  assign enter_play = (state == S_READY) && (timer == RDY_LAST);
  assign stay_play  = (state == S_PLAY) && !caught && !level_clear;
  // Mask is built from next-frame timer so ghost_en stays registered.
  assign mask_timer = enter_play ? '0 : timer_inc;
  assign state_o    = state;

  ghost_release_mask #(
    .NUM_GHOSTS    (NUM_GHOSTS),
    .RELEASE_FRAMES(RELEASE_FRAMES),
    .TIMER_W       (TIMER_W)
  ) u_mask (
    .timer(mask_timer),
    .play (enter_play | stay_play),
    .mask (mask)
  );

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= S_IDLE;
      timer      <= '0;
      lives      <= LIVES0;
      game_reset <= 1'b0;
      ghost_en   <= '0;
      game_over  <= 1'b0;
      win        <= 1'b0;
      // A key held through reset must be released before it starts a game.
      start_q    <= 1'b1;
    end else begin
      start_q    <= start;
      game_reset <= 1'b0;
      ghost_en   <= mask;
      case (state)
        S_IDLE, S_OVER, S_WIN: begin
          if (start_edge) begin
            state      <= S_READY;
            lives      <= LIVES0;
            game_reset <= 1'b1;
            timer      <= '0;
            game_over  <= 1'b0;
            win        <= 1'b0;
          end
        end
        S_READY: begin
          if (enter_play) begin
            state <= S_PLAY;
            timer <= '0;
          end else begin
            timer <= timer_inc;
          end
        end
        S_PLAY: begin
          if (caught) begin
            state <= S_DYING;
            timer <= '0;
          end else if (level_clear) begin
            state <= S_WIN;
            win   <= 1'b1;
          end else begin
            timer <= timer_inc;
          end
        end
        S_DYING: begin
          if (timer == DTH_LAST) begin
            if (lives == 2'd1) begin
              lives     <= 2'd0;
              state     <= S_OVER;
              game_over <= 1'b1;
            end else begin
              lives      <= lives - 2'd1;
              game_reset <= 1'b1;
              timer      <= '0;
              state      <= S_READY;
            end
          end else begin
            timer <= timer_inc;
          end
        end
        default: begin
          state     <= S_IDLE;
          timer     <= '0;
          game_over <= 1'b0;
          win       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with short
// ready/death/release frame counts.
module tb_game_sequencer;

  logic       frame_clk = 1'b0;
  logic       Reset_n;
  logic       start;
  logic [3:0] die_vec;
  logic       level_clear;
  logic       game_reset;
  logic [3:0] ghost_en;
  logic [1:0] lives;
  logic [2:0] state_o;
  logic       game_over;
  logic       win;

  int checks   = 0;
  int failures = 0;

  always #5 frame_clk = ~frame_clk;

  game_sequencer #(
    .NUM_GHOSTS    (4),
    .START_LIVES   (3),
    .READY_FRAMES  (4),
    .DEATH_FRAMES  (3),
    .RELEASE_FRAMES(2),
    .TIMER_W       (8)
  ) dut (
    .frame_clk  (frame_clk),
    .Reset_n    (Reset_n),
    .start      (start),
    .die_vec    (die_vec),
    .level_clear(level_clear),
    .game_reset (game_reset),
    .ghost_en   (ghost_en),
    .lives      (lives),
    .state_o    (state_o),
    .game_over  (game_over),
    .win        (win)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge frame_clk);
      #1;
    end
  endtask

  task automatic start_game();
    start = 1'b0;
    tick(1);
    start = 1'b1;
    tick(1);
  endtask

  // From the READY entry frame, 4 frames later play starts.
  task automatic ready_to_play(input string tag);
    tick(3);
    check({tag, "_ready"}, state_o, 1);
    tick(1);
    check({tag, "_play"}, state_o, 2);
  endtask

  // One catch from PLAY, then run out the death frames.
  task automatic catch_once(input string tag, input int lv);
    die_vec = 4'b0010;
    tick(1);
    die_vec = 4'b0000;
    check({tag, "_dying"}, state_o, 3);
    tick(2);
    check({tag, "_dying_lives"}, lives, lv);
    tick(1);
  endtask

  initial begin
    Reset_n     = 1'b0;
    start       = 1'b0;
    die_vec     = '0;
    level_clear = 1'b0;
    tick(2);
    check("rst_state", state_o, 0);
    check("rst_lives", lives, 3);
    check("rst_ghost", ghost_en, 0);
    check("rst_greset", game_reset, 0);
    check("rst_over", game_over, 0);
    check("rst_win", win, 0);
    Reset_n = 1'b1;
    tick(2);
    check("idle_hold", state_o, 0);

    start = 1'b1;
    tick(1);
    check("start_state", state_o, 1);
    check("start_pulse", game_reset, 1);
    check("start_lives", lives, 3);
    tick(1);
    check("pulse_one", game_reset, 0);
    tick(2);
    check("ready_t3", state_o, 1);
    check("ready_ghost", ghost_en, 0);
    tick(1);
    check("play_enter", state_o, 2);
    check("rel_f0", ghost_en, 4'b0001);
    tick(1);
    check("rel_f1", ghost_en, 4'b0001);
    tick(1);
    check("rel_f2", ghost_en, 4'b0011);
    tick(2);
    check("rel_f4", ghost_en, 4'b0111);
    tick(2);
    check("rel_f6", ghost_en, 4'b1111);
    tick(5);
    check("rel_hold", ghost_en, 4'b1111);

    die_vec = 4'b0100;
    tick(1);
    die_vec = 4'b0000;
    check("die_state", state_o, 3);
    check("die_ghost", ghost_en, 0);
    tick(2);
    check("die_wait", state_o, 3);
    check("die_nopulse", game_reset, 0);
    tick(1);
    check("die_lives", lives, 2);
    check("die_pulse", game_reset, 1);
    check("die_ready", state_o, 1);
    tick(1);
    check("die_pulse_one", game_reset, 0);
    tick(2);
    tick(1);
    check("p2_play", state_o, 2);

    die_vec     = 4'b0001;
    level_clear = 1'b1;
    tick(1);
    die_vec     = 4'b0000;
    level_clear = 1'b0;
    check("prio_state", state_o, 3);
    check("prio_win", win, 0);
    tick(3);
    check("prio_lives", lives, 1);
    check("prio_ready", state_o, 1);

    ready_to_play("p3");
    catch_once("c3", 1);
    check("over_state", state_o, 4);
    check("over_lives", lives, 0);
    check("over_flag", game_over, 1);
    check("over_nopulse", game_reset, 0);
    tick(3);
    check("over_hold", state_o, 4);

    start_game();
    check("restart_state", state_o, 1);
    check("restart_lives", lives, 3);
    check("restart_pulse", game_reset, 1);
    check("restart_over", game_over, 0);

    ready_to_play("w");
    tick(1);
    level_clear = 1'b1;
    tick(1);
    level_clear = 1'b0;
    check("win_state", state_o, 5);
    check("win_flag", win, 1);
    check("win_ghost", ghost_en, 0);
    start_game();
    check("win_restart", state_o, 1);
    check("win_clear", win, 0);

    ready_to_play("r1");
    catch_once("r1", 3);
    check("r1_lives", lives, 2);
    ready_to_play("r2");
    die_vec = 4'b1000;
    tick(2);
    die_vec = 4'b0000;
    check("r2_dying", state_o, 3);
    check("r2_lives", lives, 2);
    #2;
    Reset_n = 1'b0;
    #1;
    check("arst_state", state_o, 0);
    check("arst_lives", lives, 3);
    check("arst_ghost", ghost_en, 0);
    check("arst_pulse", game_reset, 0);
    start = 1'b1;
    tick(1);
    Reset_n = 1'b1;
    tick(3);
    check("held_start", state_o, 0);
    check("held_pulse", game_reset, 0);
    start_game();
    check("toggle_start", state_o, 1);
    check("toggle_pulse", game_reset, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
